// File: rtl/fwd_wb_pipe_pkg.sv
// Shared encodings for the pipelined write-back / forwarding block.
package fwd_wb_pipe_pkg;

   localparam logic [1:0] A3_SEL_RD   = 2'b00;
   localparam logic [1:0] A3_SEL_RT   = 2'b01;
   localparam logic [1:0] A3_SEL_RA   = 2'b10;
   localparam logic [1:0] A3_SEL_NONE = 2'b11;

   localparam logic [1:0] WD_SEL_ALU  = 2'b00;
   localparam logic [1:0] WD_SEL_DM   = 2'b01;
   localparam logic [1:0] WD_SEL_PC8  = 2'b10;
   localparam logic [1:0] WD_SEL_RSV  = 2'b11;

   localparam logic [1:0] TUSE_NONE   = 2'd3;

   // Default link register; the top exposes its own RA_IDX parameter.
   localparam int DEF_RA_IDX = 31;

   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/fwd_wb_pipe_fwd_sel.sv
// One read channel: E > M > W priority forward mux and its Tuse/Tnew stall term.
module fwd_sel
   import fwd_wb_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_ra,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_tuse,
   input  logic [REG_AW-1:0] i_a3_e,
   input  logic [1:0]        i_tnew_e,
   input  logic [DATA_W-1:0] i_val_e,
   input  logic [REG_AW-1:0] i_a3_m,
   input  logic [1:0]        i_tnew_m,
   input  logic [DATA_W-1:0] i_val_m,
   input  logic [REG_AW-1:0] i_a3_w,
   input  logic [DATA_W-1:0] i_val_w,
   output logic [DATA_W-1:0] o_fwd,
   output logic              o_stall
);

   logic w_hit_e, w_hit_m, w_hit_w;

   // A zero address never matches, so $0 always reads the GRF value.
   assign w_hit_e = (i_ra != '0) && (i_ra == i_a3_e);
   assign w_hit_m = (i_ra != '0) && (i_ra == i_a3_m);
   assign w_hit_w = (i_ra != '0) && (i_ra == i_a3_w);

   always_comb begin
      o_fwd = i_rdata;
      if (w_hit_e)      o_fwd = i_val_e;
      else if (w_hit_m) o_fwd = i_val_m;
      else if (w_hit_w) o_fwd = i_val_w;
   end

   assign o_stall = (i_tuse != TUSE_NONE) &&
                    ((w_hit_e && (i_tnew_e > i_tuse)) ||
                     (w_hit_m && (i_tnew_m > i_tuse)));

endmodule

// File: rtl/fwd_wb_pipe.sv
// D-stage A3/WD select, E/M/W destination pipeline, operand forwarding,
// load-use stall and GRF write port driven from W.
module fwd_wb_pipe
   import fwd_wb_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int NUM_RD = 2,
   parameter int RA_IDX = DEF_RA_IDX
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [REG_AW-1:0]        d_rd,
   input  logic [REG_AW-1:0]        d_rt,
   input  logic [1:0]               d_a3_sel,
   input  logic [1:0]               d_wd_sel,
   input  logic [1:0]               d_tnew,
   input  logic [DATA_W-1:0]        d_pc8,
   input  logic [NUM_RD*REG_AW-1:0] d_ra,
   input  logic [NUM_RD*DATA_W-1:0] d_rdata,
   input  logic [NUM_RD*2-1:0]      d_tuse,
   input  logic [DATA_W-1:0]        e_alu_result,
   input  logic [DATA_W-1:0]        m_dm_rd,
   input  logic                     flush,
   output logic [NUM_RD*DATA_W-1:0] d_fwd,
   output logic                     stall,
   output logic                     grf_we,
   output logic [REG_AW-1:0]        grf_a3,
   output logic [DATA_W-1:0]        grf_wd
);

   logic [REG_AW-1:0] w_a3_d;
   logic [NUM_RD-1:0] w_stall_ch;

   logic [REG_AW-1:0] r_a3_e, r_a3_m, r_a3_w;
   logic [1:0]        r_wdsel_e, r_wdsel_m;
   logic [1:0]        r_tnew_e, r_tnew_m;
   logic [DATA_W-1:0] r_pc8_e, r_res_m, r_wd_w;

   always_comb begin
      case (d_a3_sel)
         A3_SEL_RD: w_a3_d = d_rd;
         A3_SEL_RT: w_a3_d = d_rt;
         A3_SEL_RA: w_a3_d = REG_AW'(RA_IDX);
         default:   w_a3_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a3_e    <= '0;
         r_wdsel_e <= WD_SEL_ALU;
         r_tnew_e  <= '0;
         r_pc8_e   <= '0;
         r_a3_m    <= '0;
         r_wdsel_m <= WD_SEL_ALU;
         r_tnew_m  <= '0;
         r_res_m   <= '0;
         r_a3_w    <= '0;
         r_wd_w    <= '0;
      end else begin
         // stall and flush both just inject one bubble into E
         if (stall || flush) begin
            r_a3_e    <= '0;
            r_wdsel_e <= WD_SEL_ALU;
            r_tnew_e  <= '0;
            r_pc8_e   <= '0;
         end else begin
            r_a3_e    <= w_a3_d;
            r_wdsel_e <= d_wd_sel;
            r_tnew_e  <= d_tnew;
            r_pc8_e   <= d_pc8;
         end
         r_a3_m    <= r_a3_e;
         r_wdsel_m <= r_wdsel_e;
         r_tnew_m  <= sat_dec(r_tnew_e);
         r_res_m   <= (r_wdsel_e == WD_SEL_PC8) ? r_pc8_e : e_alu_result;
         r_a3_w    <= r_a3_m;
         r_wd_w    <= (r_wdsel_m == WD_SEL_DM) ? m_dm_rd : r_res_m;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_ch
      fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_sel (
         .i_ra     (d_ra[g*REG_AW +: REG_AW]),
         .i_rdata  (d_rdata[g*DATA_W +: DATA_W]),
         .i_tuse   (d_tuse[g*2 +: 2]),
         .i_a3_e   (r_a3_e),
         .i_tnew_e (r_tnew_e),
         .i_val_e  (r_pc8_e),
         .i_a3_m   (r_a3_m),
         .i_tnew_m (r_tnew_m),
         .i_val_m  (r_res_m),
         .i_a3_w   (r_a3_w),
         .i_val_w  (r_wd_w),
         .o_fwd    (d_fwd[g*DATA_W +: DATA_W]),
         .o_stall  (w_stall_ch[g])
      );
   end

   assign stall = |w_stall_ch;

   // W still holds a live write during the reset cycle; suppress it.
   assign grf_we = (r_a3_w != '0) && !reset;
   assign grf_a3 = r_a3_w;
   assign grf_wd = r_wd_w;

endmodule

// File: tb/tb_fwd_wb_pipe.sv
// Directed vector bench for fwd_wb_pipe: one table row per clock cycle.
module tb_fwd_wb_pipe;
   import fwd_wb_pipe_pkg::*;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int NUM_RD = 2;
   localparam logic [31:0] A0 = 32'hA000_0000;
   localparam logic [31:0] B0 = 32'hB000_0000;
   localparam int NV = 26;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [REG_AW-1:0]        d_rd, d_rt;
   logic [1:0]               d_a3_sel, d_wd_sel, d_tnew;
   logic [DATA_W-1:0]        d_pc8;
   logic [NUM_RD*REG_AW-1:0] d_ra;
   logic [NUM_RD*DATA_W-1:0] d_rdata;
   logic [NUM_RD*2-1:0]      d_tuse;
   logic [DATA_W-1:0]        e_alu_result, m_dm_rd;
   logic                     flush;
   logic [NUM_RD*DATA_W-1:0] d_fwd;
   logic                     stall, grf_we;
   logic [REG_AW-1:0]        grf_a3;
   logic [DATA_W-1:0]        grf_wd;

   fwd_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(NUM_RD), .RA_IDX(31)) dut (
      .clk(clk), .reset(reset), .d_rd(d_rd), .d_rt(d_rt), .d_a3_sel(d_a3_sel),
      .d_wd_sel(d_wd_sel), .d_tnew(d_tnew), .d_pc8(d_pc8), .d_ra(d_ra),
      .d_rdata(d_rdata), .d_tuse(d_tuse), .e_alu_result(e_alu_result),
      .m_dm_rd(m_dm_rd), .flush(flush), .d_fwd(d_fwd), .stall(stall),
      .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  a3s, wds, tnew;
      logic [4:0]  rd, rt;
      logic [31:0] pc8;
      logic [4:0]  ra0, ra1;
      logic [1:0]  tu0, tu1;
      logic [31:0] alu, dm;
      logic        flush;
      logic        e_stall;
      logic [31:0] e_f0, e_f1;
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
   } vec_t;

   vec_t tbl [NV];
   int n_vec  = 0;
   int n_miss = 0;

   function automatic vec_t mk(
      input logic [1:0] a3s, wds, tnew, input logic [4:0] rd, rt, input logic [31:0] pc8,
      input logic [4:0] ra0, input logic [1:0] tu0, input logic [4:0] ra1, input logic [1:0] tu1,
      input logic [31:0] alu, dm, input logic fl,
      input logic es, input logic [31:0] ef0, ef1, input logic ewe, input logic [4:0] ea3,
      input logic [31:0] ewd);
      vec_t v;
      v.rst = 1'b0; v.a3s = a3s; v.wds = wds; v.tnew = tnew; v.rd = rd; v.rt = rt;
      v.pc8 = pc8; v.ra0 = ra0; v.tu0 = tu0; v.ra1 = ra1; v.tu1 = tu1; v.alu = alu;
      v.dm = dm; v.flush = fl; v.e_stall = es; v.e_f0 = ef0; v.e_f1 = ef1;
      v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset        = v.rst;
      d_rd         = v.rd;
      d_rt         = v.rt;
      d_a3_sel     = v.a3s;
      d_wd_sel     = v.wds;
      d_tnew       = v.tnew;
      d_pc8        = v.pc8;
      d_ra         = {v.ra1, v.ra0};
      d_rdata      = {B0 | {27'b0, v.ra1}, A0 | {27'b0, v.ra0}};
      d_tuse       = {v.tu1, v.tu0};
      e_alu_result = v.alu;
      m_dm_rd      = v.dm;
      flush        = v.flush;
   endtask

   task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
      end
   endtask

   task automatic chk(input int idx, input vec_t v);
      n_vec++;
      cmp("stall",  idx, {31'b0, stall},  {31'b0, v.e_stall});
      cmp("fwd0",   idx, d_fwd[31:0],     v.e_f0);
      cmp("fwd1",   idx, d_fwd[63:32],    v.e_f1);
      cmp("grf_we", idx, {31'b0, grf_we}, {31'b0, v.e_we});
      cmp("grf_a3", idx, {27'b0, grf_a3}, {27'b0, v.e_a3});
      cmp("grf_wd", idx, grf_wd,          v.e_wd);
   endtask

   initial begin
      vec_t v;
      // ALU back-to-back, then load-use with one stall cycle
      tbl[0]  = mk(A3_SEL_RD,  WD_SEL_ALU, 1,  8, 0, 32'h100, 0, 3, 0, 3, 0, 0, 0,  0, A0, B0, 0, 0, 0);
      tbl[1]  = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h104, 8, 1, 0, 3, 5, 0, 0,  0, 32'h100, B0, 0, 0, 0);
      tbl[2]  = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h108, 8, 1, 0, 3, 0, 0, 0,  0, 5, B0, 0, 0, 0);
      tbl[3]  = mk(A3_SEL_RT,  WD_SEL_DM,  2,  0, 9, 32'h10C, 8, 1, 0, 3, 0, 0, 0,  0, 5, B0, 1, 8, 5);
      tbl[4]  = mk(A3_SEL_RD,  WD_SEL_ALU, 1, 10, 0, 32'h110, 9, 1, 9, 3, 32'h40, 0, 0,  1, 32'h10C, 32'h10C, 0, 0, 0);
      tbl[5]  = mk(A3_SEL_RD,  WD_SEL_ALU, 1, 10, 0, 32'h110, 9, 1, 9, 3, 0, 32'hDEADBEEF, 0,  0, 32'h40, 32'h40, 0, 0, 0);
      tbl[6]  = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h114, 9, 0, 10, 0, 32'h77, 0, 0,  1, 32'hDEADBEEF, 32'h110, 1, 9, 32'hDEADBEEF);
      tbl[7]  = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h114, 9, 0, 10, 0, 0, 0, 0,  0, A0 | 32'h9, 32'h77, 0, 0, 0);
      // jal and beq on $31, then write to $0
      tbl[8]  = mk(A3_SEL_RA,  WD_SEL_PC8, 0,  0, 0, 32'h3008, 0, 3, 0, 3, 0, 0, 0,  0, A0, B0, 1, 10, 32'h77);
      tbl[9]  = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h300C, 31, 0, 0, 0, 32'h1234, 0, 0,  0, 32'h3008, B0, 0, 0, 0);
      tbl[10] = mk(A3_SEL_RD,  WD_SEL_ALU, 1,  0, 0, 32'h200, 31, 1, 0, 3, 0, 0, 0,  0, 32'h3008, B0, 0, 0, 0);
      tbl[11] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h204, 0, 0, 0, 0, 7, 0, 0,  0, A0, B0, 1, 31, 32'h3008);
      tbl[12] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h208, 0, 0, 0, 0, 0, 0, 0,  0, A0, B0, 0, 0, 0);
      tbl[13] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h20C, 0, 0, 0, 0, 0, 0, 0,  0, A0, B0, 0, 0, 7);
      // E/M/W all target $4
      tbl[14] = mk(A3_SEL_RD,  WD_SEL_ALU, 1,  4, 0, 32'h400, 0, 3, 0, 3, 0, 0, 0,  0, A0, B0, 0, 0, 0);
      tbl[15] = mk(A3_SEL_RD,  WD_SEL_ALU, 1,  4, 0, 32'h404, 0, 3, 0, 3, 32'h11, 0, 0,  0, A0, B0, 0, 0, 0);
      tbl[16] = mk(A3_SEL_RT,  WD_SEL_PC8, 0,  0, 4, 32'h408, 0, 3, 0, 3, 32'h22, 0, 0,  0, A0, B0, 0, 0, 0);
      tbl[17] = mk(A3_SEL_RD,  WD_SEL_ALU, 1,  4, 0, 32'h40C, 4, 0, 4, 1, 32'h9999, 0, 0,  0, 32'h408, 32'h408, 1, 4, 32'h11);
      tbl[18] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h410, 4, 0, 4, 1, 32'h33, 0, 0,  1, 32'h40C, 32'h40C, 1, 4, 32'h22);
      tbl[19] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h410, 4, 0, 4, 1, 0, 0, 0,  0, 32'h33, 32'h33, 1, 4, 32'h408);
      // flush alone, then flush coinciding with stall
      tbl[20] = mk(A3_SEL_RD,  WD_SEL_ALU, 1, 12, 0, 32'h500, 4, 0, 0, 3, 0, 0, 1,  0, 32'h33, B0, 1, 4, 32'h33);
      tbl[21] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h504, 12, 0, 0, 3, 0, 0, 0,  0, A0 | 32'hC, B0, 0, 0, 0);
      tbl[22] = mk(A3_SEL_RT,  WD_SEL_DM,  2,  0, 13, 32'h600, 0, 3, 0, 3, 0, 0, 0,  0, A0, B0, 0, 0, 0);
      tbl[23] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h604, 13, 0, 0, 3, 32'h50, 0, 1,  1, 32'h600, B0, 0, 0, 0);
      tbl[24] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h604, 13, 0, 0, 3, 0, 32'hCAFE, 0,  1, 32'h50, B0, 0, 0, 0);
      tbl[25] = mk(A3_SEL_NONE,WD_SEL_ALU, 0,  0, 0, 32'h604, 13, 0, 0, 3, 0, 0, 0,  0, 32'hCAFE, B0, 1, 13, 32'hCAFE);

      v = mk(A3_SEL_NONE, WD_SEL_ALU, 0, 0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, A0, B0, 0, 0, 0);
      v.rst = 1'b1;
      drive(v);
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         @(negedge clk);
         chk(i, tbl[i]);
      end

      // Three writes in flight, then a one-cycle reset pulse
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(mk(A3_SEL_RD, WD_SEL_ALU, 1, 5'(20 + i), 0, 32'h700, 0, 3, 0, 3,
                  32'(i), 0, 0, 0, 0, 0, 0, 0, 0));
      end
      @(posedge clk); #1;
      v = mk(A3_SEL_NONE, WD_SEL_ALU, 0, 0, 0, 0, 0, 3, 0, 3, 3, 0, 0, 0, A0, B0, 0, 0, 0);
      v.rst = 1'b1;
      drive(v);
      @(negedge clk);
      n_vec++;
      cmp("grf_we_in_reset", 100, {31'b0, grf_we}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         v = mk(A3_SEL_NONE, WD_SEL_ALU, 0, 0, 0, 0, 22, 0, 21, 0, 0, 0, 0,
                0, A0 | 32'h16, B0 | 32'h15, 0, 0, 0);
         drive(v);
         @(negedge clk);
         chk(101 + i, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
